// File: rtl/fsbm_search_if.sv
// Handshake and memory-address bundle between the full-search sequencer and its
// datapath/consumer; the sequencer uses the slave modport.
interface fsbm_search_if #(
  parameter int SAD_W = 12,
  parameter int CA_W  = 4,
  parameter int RA_W  = 6
);
  logic             start;
  logic             busy;
  logic             rd_en;
  logic [CA_W-1:0]  cur_addr;
  logic [RA_W-1:0]  ref_addr;
  logic             sad_clr;
  logic [SAD_W-1:0] sad_in;
  logic             out_valid;
  logic             out_ready;
  logic [SAD_W-1:0] out_mad;
  logic [7:0]       out_mv;

  modport master (
    output start, sad_in, out_ready,
    input  busy, rd_en, cur_addr, ref_addr, sad_clr, out_valid, out_mad, out_mv
  );

  modport slave (
    input  start, sad_in, out_ready,
    output busy, rd_en, cur_addr, ref_addr, sad_clr, out_valid, out_mad, out_mv
  );
endinterface

// File: rtl/fsbm_search_ctrl.sv
// Full-search block-matching sequencer: walks every candidate displacement,
// issues pixel reads, tracks the minimum SAD and hands back the best vector.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | BLK_N*BLK_N pixel reads for the current candidate, col inner
// WAIT  | PIPE_LAT cycles for the datapath to finish the SAD
// CMP   | sample sad_in, update minimum, pick next candidate
// DONE  | result presented until out_ready
module fsbm_search_ctrl #(
  parameter int BLK_N    = 4,
  parameter int SR       = 4,
  parameter int SAD_W    = 12,
  parameter int PIPE_LAT = 2,
  parameter int CA_W     = 4,
  parameter int RA_W     = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  fsbm_search_if.slave  bus
);

  localparam int REF_W = BLK_N + SR - 1;
  localparam int PW    = (BLK_N > 1) ? $clog2(BLK_N) : 1;
  localparam int WW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [PW-1:0] PIX_LAST  = PW'(BLK_N - 1);
  localparam logic [3:0]    POS_LAST  = 4'(SR - 1);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(PIPE_LAT - 1);

  logic [2:0]       r_state;
  logic [PW-1:0]    r_row;
  logic [PW-1:0]    r_col;
  logic [3:0]       r_dx;
  logic [3:0]       r_dy;
  logic [WW-1:0]    r_wait;
  logic [SAD_W-1:0] r_mad;
  logic [7:0]       r_mv;

  logic w_issue;
  logic w_first_cand;
  logic w_take;

  assign w_issue      = (r_state == S_ISSUE);
  assign w_first_cand = (r_dx == 4'd0) && (r_dy == 4'd0);
  assign w_take       = w_first_cand || (bus.sad_in < r_mad);

  // Addresses are forced to zero outside ISSUE so idle buses stay quiet.
  assign bus.rd_en     = w_issue;
  assign bus.cur_addr  = w_issue ? CA_W'(32'(r_row) * 32'(BLK_N) + 32'(r_col)) : '0;
  assign bus.ref_addr  = w_issue ? RA_W'((32'(r_dy) + 32'(r_row)) * 32'(REF_W)
                                         + 32'(r_dx) + 32'(r_col)) : '0;
  assign bus.sad_clr   = w_issue && (r_row == '0) && (r_col == '0);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_mad   = r_mad;
  assign bus.out_mv    = r_mv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
      r_wait  <= '0;
      r_mad   <= '0;
      r_mv    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ISSUE;
            r_row   <= '0;
            r_col   <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
          end
        end
        S_ISSUE: begin
          if (r_col == PIX_LAST) begin
            r_col <= '0;
            if (r_row == PIX_LAST) begin
              r_row   <= '0;
              r_wait  <= WAIT_LOAD;
              r_state <= S_WAIT;
            end else begin
              r_row <= r_row + 1'b1;
            end
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_wait == '0) r_state <= S_CMP;
          else              r_wait  <= r_wait - 1'b1;
        end
        S_CMP: begin
          // strict less-than keeps the earlier candidate on ties
          if (w_take) begin
            r_mad <= bus.sad_in;
            r_mv  <= {r_dy, r_dx};
          end
          if (r_dx == POS_LAST) begin
            r_dx <= '0;
            if (r_dy == POS_LAST) begin
              r_dy    <= '0;
              r_state <= S_DONE;
            end else begin
              r_dy    <= r_dy + 1'b1;
              r_state <= S_ISSUE;
            end
          end else begin
            r_dx    <= r_dx + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsbm_search_ctrl.sv
// Directed bench for fsbm_search_ctrl: table-driven sad_in per candidate,
// hand-computed vectors, latency, addresses, handshake and reset checks.
module tb_fsbm_search_ctrl;

  logic clk;
  logic rst_n;

  fsbm_search_if #(.SAD_W(12), .CA_W(4), .RA_W(6)) bus ();

  fsbm_search_ctrl #(
    .BLK_N(4), .SR(4), .SAD_W(12), .PIPE_LAT(2), .CA_W(4), .RA_W(6)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [11:0] sad_tab [16];
  logic [3:0]  tb_clr_cnt;

  // Candidate index follows the sad_clr pulses the DUT issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           tb_clr_cnt <= '0;
    else if (bus.sad_clr) tb_clr_cnt <= tb_clr_cnt + 4'd1;
  end

  assign bus.sad_in = sad_tab[4'(tb_clr_cnt - 4'd1)];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < 16; i++) sad_tab[i] = v;
  endtask

  task automatic start_search();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // n counts cycles after the accept edge (0 = first ISSUE cycle)
  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!bus.out_valid && n < 1000) begin
      step();
      n++;
    end
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.out_valid, 0);
    chk({tag, "_busy_drop"}, bus.busy, 0);
  endtask

  int n;

  initial begin
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    fill(12'd100);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_mad", bus.out_mad, 0);
    chk("rst_mv", bus.out_mv, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single minimum at c=6, latency
    fill(12'd100);
    sad_tab[6] = 12'd40;
    start_search();
    chk("t1_first_rd_en", bus.rd_en, 1);
    chk("t1_first_clr", bus.sad_clr, 1);
    repeat (16) step();
    chk("t1_wait_rd_en", bus.rd_en, 0);
    chk("t1_wait_ref", bus.ref_addr, 0);
    wait_valid(16, n);
    chk("t1_latency", n + 1, 305);
    chk("t1_mv", bus.out_mv, 8'h12);
    chk("t1_mad", bus.out_mad, 40);
    accept("t1");

    // 2: tie between c=3 and c=9
    fill(12'd50);
    sad_tab[3] = 12'd10;
    sad_tab[9] = 12'd10;
    start_search();
    wait_valid(0, n);
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_mv", bus.out_mv, 8'h03);
    chk("t2_mad", bus.out_mad, 10);
    accept("t2");

    // 3: addresses of c=5 (dy=1,dx=1)
    fill(12'd100);
    start_search();
    repeat (94) step();
    chk("t3_clr_cmp", bus.sad_clr, 0);
    step();
    chk("t3_clr_first", bus.sad_clr, 1);
    chk("t3_ref_00", bus.ref_addr, 8);
    step();
    chk("t3_clr_second", bus.sad_clr, 0);
    repeat (10) step();
    chk("t3_rd_en", bus.rd_en, 1);
    chk("t3_cur", bus.cur_addr, 11);
    chk("t3_ref", bus.ref_addr, 25);
    wait_valid(106, n);
    chk("t3_mv", bus.out_mv, 8'h00);
    chk("t3_mad", bus.out_mad, 100);
    accept("t3");

    // 4: back-pressure with start pulsed in DONE
    fill(12'd100);
    sad_tab[12] = 12'd30;
    start_search();
    wait_valid(0, n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.start = (i >= 3 && i <= 5);
      step();
    end
    bus.start = 1'b0;
    chk("t4_hold_valid", bus.out_valid, 1);
    chk("t4_hold_busy", bus.busy, 1);
    chk("t4_hold_mad", bus.out_mad, 30);
    chk("t4_hold_mv", bus.out_mv, 8'h30);
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("t4_acc_valid", bus.out_valid, 0);
    chk("t4_acc_busy", bus.busy, 0);
    step();
    chk("t4_start_ignored", bus.busy, 0);
    chk("t4_keep_mad", bus.out_mad, 30);

    // 5: reset mid-ISSUE of c=7, then full rerun
    fill(12'd100);
    sad_tab[10] = 12'd7;
    start_search();
    repeat (138) step();
    chk("t5_pre_rd_en", bus.rd_en, 1);
    chk("t5_pre_mad", bus.out_mad, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_rd_en", bus.rd_en, 0);
    chk("t5_rst_cur", bus.cur_addr, 0);
    chk("t5_rst_ref", bus.ref_addr, 0);
    chk("t5_rst_clr", bus.sad_clr, 0);
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_mad", bus.out_mad, 0);
    chk("t5_rst_mv", bus.out_mv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_search();
    wait_valid(0, n);
    chk("t5_latency", n + 1, 305);
    chk("t5_mv", bus.out_mv, 8'h22);
    chk("t5_mad", bus.out_mad, 7);
    accept("t5");

    // 6: all-max and last-candidate zero
    fill(12'd4095);
    start_search();
    wait_valid(0, n);
    chk("t6a_mv", bus.out_mv, 8'h00);
    chk("t6a_mad", bus.out_mad, 4095);
    accept("t6a");
    sad_tab[15] = 12'd0;
    start_search();
    wait_valid(0, n);
    chk("t6b_mv", bus.out_mv, 8'h33);
    chk("t6b_mad", bus.out_mad, 0);
    accept("t6b");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
